// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, ready/valid output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN (sense set by PARITY_ODD).
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_rdat,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rdat_q, rdat_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc_q, par_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic start_edge_c, vote_pt_c, wrap_c, vote_c, commit_c, accept_c;

  // Synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge_c = prev_q & ~sync2_q;
  assign vote_pt_c    = (cnt_q == CNT_W'(HALF + 1));
  assign wrap_c       = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  // Third sample is the live synchronised value at HALF+1
  assign vote_c       = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign accept_c     = valid_q & data_ready;

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap_c ? '0 : cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    ferr_acc_d  = ferr_acc_q;
    rdat_d      = rdat_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    commit_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_d    = par_acc_q;
    perr_acc_d   = perr_acc_q;
    parity_err_d = parity_err_q;
`endif

    if (cnt_q == CNT_W'(HALF - 1)) samp_d[0] = sync2_q;
    if (cnt_q == CNT_W'(HALF))     samp_d[1] = sync2_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_edge_c) begin
          state_d    = S_START;
          bit_d      = '0;
          ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_acc_d  = 1'b0;
          perr_acc_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (vote_pt_c && vote_c) state_d = S_IDLE;
        else if (wrap_c)         state_d = S_DATA;
      end
      S_DATA: begin
        if (vote_pt_c) begin
          shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          par_acc_d = par_acc_q ^ vote_c;
`endif
        end
        if (wrap_c) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (vote_pt_c) perr_acc_d = par_acc_q ^ vote_c ^ PARITY_ODD;
        if (wrap_c)    state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (vote_pt_c) begin
          if (!vote_c) ferr_acc_d = 1'b1;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d  = S_IDLE;
            commit_c = 1'b1;
          end
        end else if (wrap_c) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit_c) begin
      rdat_d      = shift_q;
      frame_err_d = ferr_acc_d;
      valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err_d = perr_acc_q;
`endif
      if (valid_q && !accept_c) overrun_d = 1'b1;
    end else if (accept_c) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      ferr_acc_q  <= 1'b0;
      rdat_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      ferr_acc_q  <= ferr_acc_d;
      rdat_q      <= rdat_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_acc_q    <= 1'b0;
      perr_acc_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_acc_q    <= par_acc_d;
      perr_acc_q   <= perr_acc_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign o_rdat     = rdat_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
